// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefNrd   = 2;

    // Bulk-clear sweep engine states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } clrStateE;

    // Number of registers addressed by an addrW-bit address
    function automatic int unsigned depthOf(input int unsigned addrW);
        return 32'd1 << addrW;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage select, write bypass and zero-register override.
// Optional build macro: REGFILE_ZERO_REG_EN (address 0 always reads zero).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = depthOf(ADDR_W)
) (
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] storage [DEPTH],
    input  logic              wrLive,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    // Select storage, let a live write to the same address bypass it
    always_comb begin
        rdData = storage[rdAddr];
        if (wrLive && (rdAddr == wrAddr)) begin
            rdData = wrData;
        end
`ifdef REGFILE_ZERO_REG_EN
        // The override wins over bypass so r0 never shows a transient value
        if (rdAddr == '0) begin
            rdData = '0;
        end
`endif
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NRD combinational read ports with write bypass,
// one write port, and a one-register-per-cycle bulk-clear sweep engine.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NRD    = DefNrd
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int unsigned       DEPTH   = depthOf(ADDR_W);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] memQ [DEPTH];
    clrStateE          stateQ, stateD;
    logic [ADDR_W-1:0] ptrQ, ptrD;
    logic              wrLive;
    logic              wrCommit;

    // Writeback only reaches storage or the bypass while the sweep engine is idle
    assign wrLive = wr_en && (stateQ == StIdle);
`ifdef REGFILE_ZERO_REG_EN
    assign wrCommit = wrLive && (wr_addr != '0);
`else
    assign wrCommit = wrLive;
`endif

    // Storage: sweep zeroing has priority, otherwise the writeback port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                memQ[i] <= '0;
            end
        end else if (stateQ == StSweep) begin
            memQ[ptrQ] <= '0;
        end else if (wrCommit) begin
            memQ[wr_addr] <= wr_data;
        end
    end

    // Sweep engine state and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            ptrQ   <= '0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
        end
    end

    // Sweep engine next state and handshake outputs
    always_comb begin
        stateD   = stateQ;
        ptrD     = ptrQ;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (clr_req) begin
                    stateD = StSweep;
                    ptrD   = '0;
                end
            end
            StSweep: begin
                clr_busy = 1'b1;
                ptrD     = ptrQ + ADDR_W'(1);
                // Explicit terminal compare; the wrap to 0 is not relied on
                if (ptrQ == LastIdx) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                clr_done = 1'b1;
                stateD   = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Independent read ports
    for (genvar p = 0; p < int'(NRD); p++) begin : gRdPort
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) uRdPort (
            .rdAddr  (rd_addr[p*ADDR_W +: ADDR_W]),
            .storage (memQ),
            .wrLive  (wrLive),
            .wrAddr  (wr_addr),
            .wrData  (wr_data),
            .rdData  (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (DATA_W=16, ADDR_W=4, NRD=2).
// Honours REGFILE_ZERO_REG_EN when the bundle is built with it.
module tb_regfile_param;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    int total = 0;
    int bad   = 0;

    regfile_param #(
        .DATA_W (16),
        .ADDR_W (4),
        .NRD    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wrEn;
        logic [3:0]  wrAddr;
        logic [15:0] wrData;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vecT;

    vecT vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reads every register on both ports, expecting zero everywhere
    task automatic checkAllZero(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            #1;
            check(name, {16'h0, rd_data[15:0]}, 32'h0);
            check(name, {16'h0, rd_data[31:16]}, 32'h0);
        end
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    // Value a filled register should hold before any sweep touches it
    function automatic logic [15:0] filled(input logic [15:0] base, input int i);
        if (ZeroReg && i == 0) return 16'h0;
        return base + 16'(i);
    endfunction

    initial begin
        int    doneCyc [2];
        int    nDone;
        bit    sawDone;
        bit    seen;

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        clr_req = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("reset_busy", {31'h0, clr_busy}, 32'h0);
        check("reset_done", {31'h0, clr_done}, 32'h0);
        checkAllZero("reset_read");
        @(posedge clk);
        #1;

        // Directed read/write/bypass vectors
        vecs[0] = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd6, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 4'd5, 16'h0000, 4'd5, 4'd6, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 4'd3, 16'h00A3, 4'd3, 4'd3, 16'h00A3, 16'h00A3};
        vecs[3] = '{1'b1, 4'd3, 16'h0033, 4'd5, 4'd3, 16'hBEEF, 16'h0033};
        vecs[4] = '{1'b0, 4'd0, 16'h0000, 4'd3, 4'd0, 16'h0033, 16'h0000};
        vecs[5] = '{1'b1, 4'd0, 16'h1234, 4'd0, 4'd5,
                    ZeroReg ? 16'h0000 : 16'h1234, 16'hBEEF};
        vecs[6] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd15,
                    ZeroReg ? 16'h0000 : 16'h1234, 16'h0000};
        for (int v = 0; v < 7; v++) begin
            wr_en   = vecs[v].wrEn;
            wr_addr = vecs[v].wrAddr;
            wr_data = vecs[v].wrData;
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            @(negedge clk);
            check($sformatf("vec%0d_port0", v), {16'h0, rd_data[15:0]}, {16'h0, vecs[v].exp0});
            check($sformatf("vec%0d_port1", v), {16'h0, rd_data[31:16]}, {16'h0, vecs[v].exp1});
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;

        // Full sweep with writes attempted throughout
        for (int i = 0; i < 16; i++) writeReg(4'(i), 16'h1000 + 16'(i));
        clr_req = 1'b1;
        @(negedge clk);
        check("pre_sweep_busy", {31'h0, clr_busy}, 32'h0);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 16'h5555;
        for (int k = 0; k < 16; k++) begin
            // ptr == k in this cycle: k still holds its old value, k-1 is cleared
            rd_addr = {4'((k + 15) % 16), 4'(k)};
            @(negedge clk);
            check($sformatf("sweep%0d_busy", k), {31'h0, clr_busy}, 32'h1);
            check($sformatf("sweep%0d_done", k), {31'h0, clr_done}, 32'h0);
            check($sformatf("sweep%0d_cur", k), {16'h0, rd_data[15:0]},
                  {16'h0, filled(16'h1000, k)});
            if (k > 0) begin
                check($sformatf("sweep%0d_prev", k), {16'h0, rd_data[31:16]}, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        rd_addr = {4'd14, 4'd15};
        @(negedge clk);
        check("done_pulse", {31'h0, clr_done}, 32'h1);
        check("done_busy", {31'h0, clr_busy}, 32'h0);
        check("done_no_bypass", {16'h0, rd_data[15:0]}, 32'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("after_done_pulse", {31'h0, clr_done}, 32'h0);
        check("after_done_busy", {31'h0, clr_busy}, 32'h0);
        checkAllZero("after_sweep");
        @(posedge clk);
        #1;

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) writeReg(4'(i), 16'h2000 + 16'(i));
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rd_addr = {4'd8, 4'd9};
        #1;
        check("mid_ptr9_cur", {16'h0, rd_data[15:0]}, 32'h2009);
        check("mid_ptr9_prev", {16'h0, rd_data[31:16]}, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_reset_busy", {31'h0, clr_busy}, 32'h0);
        check("mid_reset_done", {31'h0, clr_done}, 32'h0);
        checkAllZero("mid_reset_read");
        @(posedge clk);
        #1;
        rst = 1'b1;
        sawDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            sawDone = sawDone | clr_done;
        end
        check("mid_reset_no_done", {31'h0, sawDone}, 32'h0);
        @(posedge clk);
        #1;

        // Write and clear request in the same idle cycle
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 16'h7777;
        clr_req = 1'b1;
        rd_addr = {4'd0, 4'd2};
        @(negedge clk);
        check("simul_bypass", {16'h0, rd_data[15:0]}, 32'h7777);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        clr_req = 1'b0;
        #1;
        check("simul_committed", {16'h0, rd_data[15:0]}, 32'h7777);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (clr_done) seen = 1'b1;
        end
        check("simul_done_seen", {31'h0, seen}, 32'h1);
        @(posedge clk);
        #1;
        check("simul_cleared", {16'h0, rd_data[15:0]}, 32'h0);

        // Back-to-back sweeps with clr_req held high
        clr_req = 1'b1;
        nDone   = 0;
        for (int c = 0; c < 60 && nDone < 2; c++) begin
            @(negedge clk);
            if (clr_done) begin
                doneCyc[nDone] = c;
                nDone++;
            end
        end
        clr_req = 1'b0;
        check("b2b_two_dones", nDone, 2);
        if (nDone == 2) begin
            check("b2b_period", doneCyc[1] - doneCyc[0], 18);
        end
        @(posedge clk);
        #1;
        check("b2b_idle_busy", {31'h0, clr_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
